// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB PID constants and the IN scheduler state type
//
// Purpose: PID encodings used by the token decoder, handshake receiver and
// packet transmitter, plus the state enum of usb_in_ep_sched.
// Ports:   none (package).

package usb_pkg;

  // Token PIDs
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  // Data PIDs
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  // Handshake PIDs
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TX_DATA = 2'd1,
    ST_WAIT_HS = 2'd2,
    ST_TX_HS   = 2'd3
  } in_sched_state_t;

endpackage

// File: rtl/usb_in_ep_sched.sv
// rtl/usb_in_ep_sched.sv - IN transaction scheduler for the shared USB tx engine
//
// Purpose: on an IN token addressed to this device, answers with DATA0/DATA1,
// NAK or STALL through the packet transmitter, then waits for the host
// handshake to commit the endpoint buffer and flip its data toggle.
// Ports:
//   clk_48mhz, reset           clock, synchronous active-high reset
//   dev_addr                   current device address
//   token_valid/pid/addr/endp  decoded token (one-cycle pulse)
//   ep_in_ready/stall/len      per-endpoint status, sampled at token acceptance
//   hs_valid, hs_pid           received handshake (one-cycle pulse)
//   tx_pkt_end                 tx engine finished EOP (one-cycle pulse)
//   toggle_clear/set           per-endpoint toggle overrides
//   tx_pkt_start/pid/len       packet request to the tx engine
//   ep_sel                     endpoint whose buffer the tx engine reads
//   ep_commit                  one-cycle pulse, endpoint discards sent packet
//   data_toggle                current toggle per endpoint (0 = DATA0)
//   busy                       high whenever not idle

module usb_in_ep_sched
  import usb_pkg::*;
#(
  parameter int NUM_EP         = 4,
  parameter int TIMEOUT_CYCLES = 1536,
  parameter int LEN_W          = 7
) (
  input  logic                    clk_48mhz,
  input  logic                    reset,
  input  logic [6:0]              dev_addr,
  input  logic                    token_valid,
  input  logic [3:0]              token_pid,
  input  logic [6:0]              token_addr,
  input  logic [3:0]              token_endp,
  input  logic [NUM_EP-1:0]       ep_in_ready,
  input  logic [NUM_EP-1:0]       ep_in_stall,
  input  logic [NUM_EP*LEN_W-1:0] ep_in_len,
  input  logic                    hs_valid,
  input  logic [3:0]              hs_pid,
  input  logic                    tx_pkt_end,
  input  logic [NUM_EP-1:0]       toggle_clear,
  input  logic [NUM_EP-1:0]       toggle_set,
  output logic                    tx_pkt_start,
  output logic [3:0]              tx_pid,
  output logic [LEN_W-1:0]        tx_len,
  output logic [3:0]              ep_sel,
  output logic [NUM_EP-1:0]       ep_commit,
  output logic [NUM_EP-1:0]       data_toggle,
  output logic                    busy
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  in_sched_state_t     state, state_next;
  logic [TIMER_W-1:0]  timer, timer_next;
  logic                tx_pkt_start_next;
  logic [3:0]          tx_pid_next;
  logic [LEN_W-1:0]    tx_len_next;
  logic [3:0]          ep_sel_next;
  logic [NUM_EP-1:0]   ep_commit_next;
  logic [NUM_EP-1:0]   data_toggle_next;

  logic                token_hit;
  logic                ack_rx;
  logic                tok_stall;
  logic                tok_ready;
  logic                tok_toggle;
  logic [LEN_W-1:0]    tok_len;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state        <= ST_IDLE;
      timer        <= '0;
      tx_pkt_start <= 1'b0;
      tx_pid       <= 4'b0000;
      tx_len       <= '0;
      ep_sel       <= 4'd0;
      ep_commit    <= '0;
      data_toggle  <= '0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      tx_pkt_start <= tx_pkt_start_next;
      tx_pid       <= tx_pid_next;
      tx_len       <= tx_len_next;
      ep_sel       <= ep_sel_next;
      ep_commit    <= ep_commit_next;
      data_toggle  <= data_toggle_next;
    end
  end

  always_comb begin
    state_next        = state;
    timer_next        = timer;
    tx_pkt_start_next = 1'b0;
    tx_pid_next       = tx_pid;
    tx_len_next       = tx_len;
    ep_sel_next       = ep_sel;
    ep_commit_next    = '0;
    data_toggle_next  = data_toggle;
    ack_rx            = 1'b0;
    tok_stall         = 1'b0;
    tok_ready         = 1'b0;
    tok_toggle        = 1'b0;
    tok_len           = '0;

    // Mux out the addressed endpoint's status; a loop keeps the select
    // legal when token_endp can exceed NUM_EP-1.
    for (int i = 0; i < NUM_EP; i++) begin
      if (token_endp == 4'(i)) begin
        tok_stall  = ep_in_stall[i];
        tok_ready  = ep_in_ready[i];
        tok_toggle = data_toggle[i];
        tok_len    = ep_in_len[i*LEN_W +: LEN_W];
      end
    end

    token_hit = token_valid && (token_pid == PID_IN) && (token_addr == dev_addr) &&
                ({1'b0, token_endp} < 5'(NUM_EP));

    case (state)
      ST_IDLE: begin
        if (token_hit) begin
          ep_sel_next       = token_endp;
          tx_pkt_start_next = 1'b1;
          if (tok_stall) begin
            tx_pid_next = PID_STALL;
            tx_len_next = '0;
            state_next  = ST_TX_HS;
          end else if (tok_ready) begin
            tx_pid_next = tok_toggle ? PID_DATA1 : PID_DATA0;
            tx_len_next = tok_len;
            state_next  = ST_TX_DATA;
          end else begin
            tx_pid_next = PID_NAK;
            tx_len_next = '0;
            state_next  = ST_TX_HS;
          end
        end
      end

      ST_TX_DATA: begin
        if (tx_pkt_end) begin
          timer_next = '0;
          state_next = ST_WAIT_HS;
        end
      end

      ST_WAIT_HS: begin
        // A new token means the host gave up on this handshake; the packet
        // stays queued so the host's retry gets the same data PID.
        if (hs_valid) begin
          ack_rx     = (hs_pid == PID_ACK);
          state_next = ST_IDLE;
        end else if (token_valid || (timer == TIMER_LAST)) begin
          state_next = ST_IDLE;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end

      ST_TX_HS: begin
        if (tx_pkt_end) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // Toggle priority: clear, then set, then the ACK flip.
    for (int i = 0; i < NUM_EP; i++) begin
      ep_commit_next[i] = ack_rx && (ep_sel == 4'(i));
      if (toggle_clear[i]) begin
        data_toggle_next[i] = 1'b0;
      end else if (toggle_set[i]) begin
        data_toggle_next[i] = 1'b1;
      end else if (ep_commit_next[i]) begin
        data_toggle_next[i] = ~data_toggle[i];
      end
    end
  end

endmodule

// File: tb/tb_usb_in_ep_sched.sv
// tb/tb_usb_in_ep_sched.sv - directed self-checking bench for usb_in_ep_sched

module tb_usb_in_ep_sched;

  localparam int NUM_EP = 4;
  localparam int TO     = 1536;
  localparam int LEN_W  = 7;

  localparam logic [3:0] P_OUT   = 4'b0001;
  localparam logic [3:0] P_IN    = 4'b1001;
  localparam logic [3:0] P_DATA0 = 4'b0011;
  localparam logic [3:0] P_DATA1 = 4'b1011;
  localparam logic [3:0] P_ACK   = 4'b0010;
  localparam logic [3:0] P_NAK   = 4'b1010;
  localparam logic [3:0] P_STALL = 4'b1110;

  logic                    clk_48mhz = 1'b0;
  logic                    reset;
  logic [6:0]              dev_addr;
  logic                    token_valid;
  logic [3:0]              token_pid;
  logic [6:0]              token_addr;
  logic [3:0]              token_endp;
  logic [NUM_EP-1:0]       ep_in_ready;
  logic [NUM_EP-1:0]       ep_in_stall;
  logic [NUM_EP*LEN_W-1:0] ep_in_len;
  logic                    hs_valid;
  logic [3:0]              hs_pid;
  logic                    tx_pkt_end;
  logic [NUM_EP-1:0]       toggle_clear;
  logic [NUM_EP-1:0]       toggle_set;
  logic                    tx_pkt_start;
  logic [3:0]              tx_pid;
  logic [LEN_W-1:0]        tx_len;
  logic [3:0]              ep_sel;
  logic [NUM_EP-1:0]       ep_commit;
  logic [NUM_EP-1:0]       data_toggle;
  logic                    busy;

  int n_cmp = 0;
  int n_err = 0;
  int commit_cnt = 0;
  int start_cnt = 0;

  always #10 clk_48mhz = ~clk_48mhz;

  usb_in_ep_sched #(
    .NUM_EP(NUM_EP), .TIMEOUT_CYCLES(TO), .LEN_W(LEN_W)
  ) dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .dev_addr(dev_addr),
    .token_valid(token_valid), .token_pid(token_pid), .token_addr(token_addr),
    .token_endp(token_endp), .ep_in_ready(ep_in_ready), .ep_in_stall(ep_in_stall),
    .ep_in_len(ep_in_len), .hs_valid(hs_valid), .hs_pid(hs_pid),
    .tx_pkt_end(tx_pkt_end), .toggle_clear(toggle_clear), .toggle_set(toggle_set),
    .tx_pkt_start(tx_pkt_start), .tx_pid(tx_pid), .tx_len(tx_len), .ep_sel(ep_sel),
    .ep_commit(ep_commit), .data_toggle(data_toggle), .busy(busy)
  );

  always @(posedge clk_48mhz) begin
    #1;
    if (|ep_commit) commit_cnt++;
    if (tx_pkt_start) start_cnt++;
  end

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_tok(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
    token_pid   = pid;
    token_addr  = addr;
    token_endp  = endp;
    token_valid = 1'b1;
    @(negedge clk_48mhz);
    token_valid = 1'b0;
  endtask

  task automatic end_pkt();
    tx_pkt_end = 1'b1;
    @(negedge clk_48mhz);
    tx_pkt_end = 1'b0;
  endtask

  task automatic send_hs(input logic [3:0] pid);
    hs_pid   = pid;
    hs_valid = 1'b1;
    @(negedge clk_48mhz);
    hs_valid = 1'b0;
  endtask

  task automatic ignore_tok(input string tag, input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp);
    int s0;
    int bad;
    s0  = start_cnt;
    bad = 0;
    send_tok(pid, addr, endp);
    repeat (20) begin
      if (busy) bad++;
      @(negedge clk_48mhz);
    end
    expect_eq({tag, "_busy_cycles"}, bad, 0);
    expect_eq({tag, "_starts"}, start_cnt - s0, 0);
    expect_eq({tag, "_pid_held"}, tx_pid, P_STALL);
  endtask

  initial begin
    int c0;
    int s0;
    int cnt;
    reset        = 1'b1;
    dev_addr     = 7'h1e;
    token_valid  = 1'b0;
    token_pid    = '0;
    token_addr   = '0;
    token_endp   = '0;
    ep_in_ready  = '0;
    ep_in_stall  = '0;
    ep_in_len    = '0;
    hs_valid     = 1'b0;
    hs_pid       = '0;
    tx_pkt_end   = 1'b0;
    toggle_clear = '0;
    toggle_set   = '0;
    repeat (2) @(negedge clk_48mhz);
    expect_eq("rst_start", tx_pkt_start, 0);
    expect_eq("rst_pid", tx_pid, 0);
    expect_eq("rst_len", tx_len, 0);
    expect_eq("rst_sel", ep_sel, 0);
    expect_eq("rst_commit", ep_commit, 0);
    expect_eq("rst_toggle", data_toggle, 0);
    expect_eq("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk_48mhz);

    // Ready then ACK on ep1
    ep_in_ready          = 4'b0010;
    ep_in_len[7 +: 7]    = 7'd8;
    send_tok(P_IN, 7'h1e, 4'd1);
    expect_eq("rdy_start", tx_pkt_start, 1);
    expect_eq("rdy_pid", tx_pid, P_DATA0);
    expect_eq("rdy_len", tx_len, 8);
    expect_eq("rdy_sel", ep_sel, 1);
    expect_eq("rdy_busy", busy, 1);
    ep_in_len[7 +: 7] = 7'd20;
    @(negedge clk_48mhz);
    expect_eq("rdy_start_pulse", tx_pkt_start, 0);
    expect_eq("rdy_len_latched", tx_len, 8);
    end_pkt();
    expect_eq("rdy_wait_busy", busy, 1);
    c0 = commit_cnt;
    send_hs(P_ACK);
    expect_eq("ack_commit", ep_commit, 4'b0010);
    expect_eq("ack_toggle", data_toggle, 4'b0010);
    expect_eq("ack_busy", busy, 0);
    @(negedge clk_48mhz);
    expect_eq("ack_commit_pulse", ep_commit, 0);
    expect_eq("ack_commit_count", commit_cnt - c0, 1);
    send_tok(P_IN, 7'h1e, 4'd1);
    expect_eq("rep_pid", tx_pid, P_DATA1);
    expect_eq("rep_len", tx_len, 20);
    end_pkt();
    c0 = commit_cnt;
    send_hs(P_NAK);
    expect_eq("hsnak_busy", busy, 0);
    expect_eq("hsnak_toggle", data_toggle, 4'b0010);
    expect_eq("hsnak_commit", commit_cnt - c0, 0);

    // NAK on ep2 (not ready, not stalled)
    c0 = commit_cnt;
    send_tok(P_IN, 7'h1e, 4'd2);
    expect_eq("nak_pid", tx_pid, P_NAK);
    expect_eq("nak_len", tx_len, 0);
    expect_eq("nak_sel", ep_sel, 2);
    end_pkt();
    expect_eq("nak_busy", busy, 0);
    expect_eq("nak_commit", commit_cnt - c0, 0);
    expect_eq("nak_toggle", data_toggle, 4'b0010);

    // STALL beats ready on ep0
    ep_in_stall       = 4'b0001;
    ep_in_ready       = 4'b0011;
    ep_in_len[0 +: 7] = 7'd9;
    c0 = commit_cnt;
    send_tok(P_IN, 7'h1e, 4'd0);
    expect_eq("stall_pid", tx_pid, P_STALL);
    expect_eq("stall_len", tx_len, 0);
    end_pkt();
    expect_eq("stall_busy", busy, 0);
    expect_eq("stall_commit", commit_cnt - c0, 0);
    ep_in_stall = 4'b0000;

    // Tokens that must be ignored
    ignore_tok("ign_addr", P_IN, 7'h05, 4'd1);
    ignore_tok("ign_endp", P_IN, 7'h1e, 4'd7);
    ignore_tok("ign_out", P_OUT, 7'h1e, 4'd1);

    // Handshake timeout on ep3
    ep_in_ready        = 4'b1010;
    ep_in_len[21 +: 7] = 7'd5;
    send_tok(P_IN, 7'h1e, 4'd3);
    expect_eq("to_pid", tx_pid, P_DATA0);
    expect_eq("to_len", tx_len, 5);
    end_pkt();
    c0  = commit_cnt;
    cnt = 0;
    while (busy && cnt < TO + 16) begin
      @(negedge clk_48mhz);
      cnt++;
    end
    expect_eq("to_cycles", cnt, TO);
    expect_eq("to_commit", commit_cnt - c0, 0);
    send_tok(P_IN, 7'h1e, 4'd3);
    expect_eq("to_retry_pid", tx_pid, P_DATA0);
    end_pkt();
    send_hs(P_ACK);
    expect_eq("to_ack_commit", ep_commit, 4'b1000);
    expect_eq("to_ack_toggle", data_toggle, 4'b1010);

    // Toggle overrides versus ACK
    toggle_clear = 4'b0010;
    @(negedge clk_48mhz);
    toggle_clear = 4'b0000;
    expect_eq("clr_only", data_toggle, 4'b1000);
    send_tok(P_IN, 7'h1e, 4'd1);
    expect_eq("pri_pid1", tx_pid, P_DATA0);
    end_pkt();
    toggle_clear = 4'b0010;
    send_hs(P_ACK);
    toggle_clear = 4'b0000;
    expect_eq("clr_vs_ack_commit", ep_commit, 4'b0010);
    expect_eq("clr_vs_ack_toggle", data_toggle, 4'b1000);
    send_tok(P_IN, 7'h1e, 4'd3);
    expect_eq("pri_pid3", tx_pid, P_DATA1);
    end_pkt();
    toggle_set = 4'b1000;
    send_hs(P_ACK);
    toggle_set = 4'b0000;
    expect_eq("set_vs_ack_commit", ep_commit, 4'b1000);
    expect_eq("set_vs_ack_toggle", data_toggle, 4'b1000);
    toggle_set = 4'b0100;
    @(negedge clk_48mhz);
    toggle_set = 4'b0000;
    expect_eq("set_only", data_toggle, 4'b1100);
    toggle_set   = 4'b0100;
    toggle_clear = 4'b0100;
    @(negedge clk_48mhz);
    toggle_set   = 4'b0000;
    toggle_clear = 4'b0000;
    expect_eq("clr_vs_set", data_toggle, 4'b1000);

    // Token during WAIT_HS drops out without commit
    send_tok(P_IN, 7'h1e, 4'd1);
    end_pkt();
    s0 = start_cnt;
    c0 = commit_cnt;
    send_tok(P_IN, 7'h1e, 4'd1);
    expect_eq("tokwait_busy", busy, 0);
    repeat (3) @(negedge clk_48mhz);
    expect_eq("tokwait_starts", start_cnt - s0, 0);
    expect_eq("tokwait_commit", commit_cnt - c0, 0);
    expect_eq("tokwait_toggle", data_toggle, 4'b1000);

    // Reset while waiting for the handshake
    send_tok(P_IN, 7'h1e, 4'd3);
    expect_eq("rstw_pid", tx_pid, P_DATA1);
    end_pkt();
    expect_eq("rstw_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk_48mhz);
    reset = 1'b0;
    expect_eq("rstw_busy", busy, 0);
    expect_eq("rstw_toggle", data_toggle, 0);
    expect_eq("rstw_commit", ep_commit, 0);
    c0 = commit_cnt;
    send_hs(P_ACK);
    repeat (3) @(negedge clk_48mhz);
    expect_eq("rstw_no_commit", commit_cnt - c0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_in_ep_sched.md
Name: usb_in_ep_sched

Overview:
- Schedules the shared USB transmit packet engine for IN transactions across NUM_EP IN endpoints.
- On a decoded IN token addressed to this device, chooses DATA0/DATA1, NAK or STALL, and starts the tx engine.
- After a data packet, waits for the host handshake, then commits the endpoint buffer and flips its data toggle.
- Sits between the token decoder / handshake receiver and the packet transmitter inside the usb core.

Parameters:
- NUM_EP, 4, number of IN endpoints (1..16).
- TIMEOUT_CYCLES, 1536, clk_48mhz cycles to wait for a handshake after the data packet's EOP.
- LEN_W, 7, byte-length width (max packet 64).

Ports:
- clk_48mhz  in  1  system clock, 48 MHz.
- reset  in  1  synchronous, active-high.
- dev_addr  in  7  current device address.
- token_valid  in  1  one-cycle pulse, decoded token available.
- token_pid  in  4  token PID.
- token_addr  in  7  token address field.
- token_endp  in  4  token endpoint field.
- ep_in_ready  in  NUM_EP  endpoint i has a packet queued.
- ep_in_stall  in  NUM_EP  endpoint i is halted.
- ep_in_len  in  NUM_EP*LEN_W  packed byte lengths; endpoint i at [i*LEN_W +: LEN_W].
- hs_valid  in  1  one-cycle pulse, handshake received from host.
- hs_pid  in  4  received handshake PID.
- tx_pkt_end  in  1  one-cycle pulse, tx engine finished EOP.
- toggle_clear  in  NUM_EP  force toggle i to DATA0.
- toggle_set  in  NUM_EP  force toggle i to DATA1.
- tx_pkt_start  out  1  one-cycle pulse, start packet.
- tx_pid  out  4  PID to send; held stable while busy.
- tx_len  out  LEN_W  payload bytes; 0 for handshakes.
- ep_sel  out  4  endpoint whose buffer the tx engine reads.
- ep_commit  out  NUM_EP  one-cycle pulse; endpoint discards its sent packet.
- data_toggle  out  NUM_EP  current toggle per endpoint (0 = DATA0).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; timer 0.
- States: IDLE, TX_DATA, WAIT_HS, TX_HS.
- IDLE: accept the token only when token_valid, token_pid==1001 (IN), token_addr==dev_addr and token_endp<NUM_EP; otherwise ignore it with no output change.
  - Accepted token: latch ep_sel=token_endp. tx_pkt_start pulses on the next cycle (latency 1), with tx_pid/tx_len valid in that same cycle.
  - Priority stall > ready > NAK:
  - stall: tx_pid=1110, tx_len=0, go to TX_HS.
  - ready: tx_pid=toggle ? 1011 : 0011, tx_len=ep_in_len[ep], go to TX_DATA.
  - neither: tx_pid=1010, tx_len=0, go to TX_HS.
- TX_DATA: on tx_pkt_end, clear the timer and go to WAIT_HS.
- TX_HS: on tx_pkt_end, go to IDLE.
- WAIT_HS: timer counts up each cycle.
  - hs_valid with hs_pid==0010 (ACK): ep_commit[ep_sel] pulses one cycle, toggle[ep_sel] inverts, go to IDLE.
  - hs_valid with any other PID: go to IDLE; no commit, no toggle change.
  - timer==TIMEOUT_CYCLES-1: go to IDLE; no commit (host retry resends same PID).
  - token_valid: treated as a missed handshake. Go to IDLE with no commit; the token is dropped.
- token_valid in TX_DATA/TX_HS: ignored. hs_valid outside WAIT_HS: ignored.
- Toggle priority per endpoint, highest first: toggle_clear > toggle_set > ACK invert. Clear/set apply in any state.
- ep_in_ready/len are sampled only at token acceptance; later changes do not affect tx_len.
- Reset in any state: IDLE next cycle, no commit pulse, all toggles 0.
- Timer width: $clog2(TIMEOUT_CYCLES); it does not wrap, and leaves WAIT_HS on terminal count.

Decomposition:
- Shared package usb_pkg: PID constants (OUT 0001, IN 1001, SOF 0101, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110) and the state enum for this block.
- No sub-module; the timer is inline.

Test Plan:
- Ready, then ACK: dev_addr=0x1e, ep1 ready, len 8; IN addr 0x1e endp 1 -> next cycle tx_pkt_start=1, tx_pid=0011, tx_len=8, ep_sel=1. tx_pkt_end then ACK -> ep_commit=0010 for one cycle, data_toggle[1]=1. Repeat IN -> tx_pid=1011.
- NAK: ep2 not ready, not stalled; IN endp 2 -> tx_pid=1010, tx_len=0; after tx_pkt_end busy=0, ep_commit never asserts, data_toggle unchanged.
- STALL priority: ep0 stall=1 and ready=1; IN endp 0 -> tx_pid=1110, tx_len=0, no commit.
- Ignored tokens: IN addr 0x05 (dev_addr 0x1e), IN endp 7 with NUM_EP=4, and OUT 0001 to addr 0x1e -> no tx_pkt_start and busy=0 for 20 cycles each.
- Timeout: DATA0 sent, no handshake -> busy falls exactly TIMEOUT_CYCLES cycles after tx_pkt_end, no commit. Retry IN -> tx_pid=0011 again.
- Priority and reset: toggle_clear[1] in the same cycle as ACK on ep1 -> data_toggle[1]=0, ep_commit[1]=1. Reset asserted in WAIT_HS -> next cycle busy=0, data_toggle=0, and no ep_commit follows.
